load_id_tracker: RTL and testbench

Parametrised outstanding-load tracker between the load unit and the HPDcache request port. Allocates a cache transaction ID per issued load, holds the load's metadata, captures the returned data (in any order), and releases completed loads to writeback. It adds selectable in-order or out-of-order release and flush-kill of in-flight IDs. It replaces the fixed-depth load buffer, and is sized from `NrLoadBufEntries`/`DcacheIdWidth`.

---
 rtl/load_id_tracker_pkg.sv | 19 +
 rtl/load_id_tracker_lzc.sv | 21 ++
 rtl/load_id_tracker.sv | 200 ++++++++++++++++++++
 tb/tb_load_id_tracker.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_id_tracker_pkg.sv
// Shared types and helpers for the outstanding-load ID tracker.
// Entry states and pointer arithmetic used by the tracker top.
package load_id_tracker_pkg;

    typedef enum logic [1:0] {
        FREE    = 2'd0,
        PENDING = 2'd1,
        DATA    = 2'd2,
        KILLED  = 2'd3
    } entry_state_e;

    function automatic int unsigned ptr_inc(
        input int unsigned ptr,
        input int unsigned n
    );
        return (ptr + 1 >= n) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/load_id_tracker_lzc.sv
// Lowest-set-bit index finder used for free/DATA entry selection.
// Reports the index of the lowest set bit and whether none is set.
module load_id_tracker_lzc #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 3
) (
    input  logic [WIDTH-1:0]     in_i,
    output logic [CNT_WIDTH-1:0] cnt_o,
    output logic                 empty_o
);

    always_comb begin
        cnt_o = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (in_i[i]) cnt_o = CNT_WIDTH'(i);
        end
    end

    assign empty_o = ~|in_i;

endmodule

// File: rtl/load_id_tracker.sv
// Outstanding-load tracker: allocates cache IDs, collects responses
// in any order and releases completed loads in-order or out-of-order.
module load_id_tracker
    import load_id_tracker_pkg::*;
#(
    parameter int NR_ENTRIES = 8,
    parameter int ID_WIDTH   = 3,
    parameter int META_WIDTH = 8,
    parameter int DATA_WIDTH = 64,
    parameter bit IN_ORDER   = 1'b0
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          alloc_valid_i,
    output logic                          alloc_ready_o,
    input  logic [META_WIDTH-1:0]         alloc_meta_i,
    output logic [ID_WIDTH-1:0]           alloc_id_o,
    input  logic                          rsp_valid_i,
    input  logic [ID_WIDTH-1:0]           rsp_id_i,
    input  logic [DATA_WIDTH-1:0]         rsp_data_i,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [META_WIDTH-1:0]         out_meta_o,
    output logic [DATA_WIDTH-1:0]         out_data_o,
    input  logic                          kill_i,
    output logic [$clog2(NR_ENTRIES+1)-1:0] count_o,
    output logic                          err_o
);

    localparam int CW = $clog2(NR_ENTRIES + 1);

    entry_state_e          state_q [NR_ENTRIES];
    entry_state_e          state_d [NR_ENTRIES];
    logic [META_WIDTH-1:0] meta_q  [NR_ENTRIES];
    logic [DATA_WIDTH-1:0] data_q  [NR_ENTRIES];

    logic [ID_WIDTH-1:0] head_q, head_d;
    logic [ID_WIDTH-1:0] tail_q, tail_d;
    logic [CW-1:0]       occ_q, occ_d;
    logic [CW-1:0]       count_q, count_d;
    logic                err_q, err_d;
    logic                lock_q;
    logic [ID_WIDTH-1:0] lock_idx_q;

    logic [NR_ENTRIES-1:0] free_vec, data_vec;
    logic [ID_WIDTH-1:0]   free_idx, data_idx, rel_idx;
    logic                  free_none, data_none;
    logic                  alloc_fire, rel_fire, head_adv;
    logic                  rsp_in_range;
    entry_state_e          rsp_st;

    always_comb begin
        free_vec = '0;
        data_vec = '0;
        for (int i = 0; i < NR_ENTRIES; i++) begin
            free_vec[i] = (state_q[i] == FREE);
            data_vec[i] = (state_q[i] == DATA);
        end
    end

    load_id_tracker_lzc #(
        .WIDTH     (NR_ENTRIES),
        .CNT_WIDTH (ID_WIDTH)
    ) u_free_lzc (
        .in_i    (free_vec),
        .cnt_o   (free_idx),
        .empty_o (free_none)
    );

    load_id_tracker_lzc #(
        .WIDTH     (NR_ENTRIES),
        .CNT_WIDTH (ID_WIDTH)
    ) u_data_lzc (
        .in_i    (data_vec),
        .cnt_o   (data_idx),
        .empty_o (data_none)
    );

    // Alloc side: in-order mode allocates strictly at the tail slot
    always_comb begin
        if (IN_ORDER) begin
            alloc_id_o    = tail_q;
            alloc_ready_o = !kill_i && (state_q[tail_q] == FREE) &&
                            (32'(occ_q) < NR_ENTRIES);
        end else begin
            alloc_id_o    = free_idx;
            alloc_ready_o = !kill_i && !free_none;
        end
    end

    assign alloc_fire = alloc_valid_i && alloc_ready_o;

    // A presented OOO entry is locked so the output cannot change under stall
    always_comb begin
        if (IN_ORDER) begin
            rel_idx     = head_q;
            out_valid_o = !kill_i && (state_q[head_q] == DATA);
        end else if (lock_q) begin
            rel_idx     = lock_idx_q;
            out_valid_o = !kill_i && (state_q[lock_idx_q] == DATA);
        end else begin
            rel_idx     = data_idx;
            out_valid_o = !kill_i && !data_none;
        end
    end

    assign out_meta_o = out_valid_o ? meta_q[rel_idx] : '0;
    assign out_data_o = out_valid_o ? data_q[rel_idx] : '0;
    assign rel_fire   = out_valid_o && out_ready_i;

    assign rsp_in_range = (32'(rsp_id_i) < NR_ENTRIES);
    assign rsp_st       = rsp_in_range ? state_q[rsp_id_i] : FREE;
    assign err_d        = rsp_valid_i &&
                          (!rsp_in_range || rsp_st == FREE || rsp_st == DATA);

    // Response first, then release/alloc, then kill on top
    always_comb begin
        for (int i = 0; i < NR_ENTRIES; i++) begin
            state_d[i] = state_q[i];
            if (rsp_valid_i && rsp_id_i == ID_WIDTH'(i)) begin
                if (state_q[i] == PENDING) state_d[i] = DATA;
                if (state_q[i] == KILLED)  state_d[i] = FREE;
            end
            if (rel_fire && rel_idx == ID_WIDTH'(i))   state_d[i] = FREE;
            if (alloc_fire && alloc_id_o == ID_WIDTH'(i)) state_d[i] = PENDING;
            if (kill_i) begin
                if (state_d[i] == PENDING) state_d[i] = KILLED;
                if (state_d[i] == DATA)    state_d[i] = FREE;
            end
        end
    end

    always_comb begin
        count_d = '0;
        for (int i = 0; i < NR_ENTRIES; i++) begin
            if (state_d[i] != FREE) count_d = count_d + CW'(1);
        end
    end

    assign head_adv = IN_ORDER && (rel_fire || ((occ_q != '0) &&
                      (state_q[head_q] == FREE || state_q[head_q] == KILLED)));

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        if (IN_ORDER) begin
            if (head_adv)
                head_d = ID_WIDTH'(ptr_inc(32'(head_q), NR_ENTRIES));
            if (alloc_fire)
                tail_d = ID_WIDTH'(ptr_inc(32'(tail_q), NR_ENTRIES));
            occ_d = occ_q + CW'(alloc_fire) - CW'(head_adv);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NR_ENTRIES; i++) state_q[i] <= FREE;
            head_q     <= '0;
            tail_q     <= '0;
            occ_q      <= '0;
            count_q    <= '0;
            err_q      <= 1'b0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            for (int i = 0; i < NR_ENTRIES; i++) state_q[i] <= state_d[i];
            head_q     <= head_d;
            tail_q     <= tail_d;
            occ_q      <= occ_d;
            count_q    <= count_d;
            err_q      <= err_d;
            lock_q     <= out_valid_o && !out_ready_i;
            lock_idx_q <= rel_idx;
        end
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NR_ENTRIES; i++) begin
            if (alloc_fire && alloc_id_o == ID_WIDTH'(i))
                meta_q[i] <= alloc_meta_i;
            if (rsp_valid_i && rsp_id_i == ID_WIDTH'(i) && state_q[i] == PENDING)
                data_q[i] <= rsp_data_i;
        end
    end

    assign count_o = count_q;
    assign err_o   = err_q;

    if (NR_ENTRIES > 2 ** ID_WIDTH || NR_ENTRIES < 2) begin : g_bad_cfg
        $error("load_id_tracker: NR_ENTRIES out of range for ID_WIDTH");
    end

    a_rsp_id : assert property (@(posedge clk_i) disable iff (!rst_ni)
        rsp_valid_i |-> rsp_in_range);

    a_alloc_id : assert property (@(posedge clk_i) disable iff (!rst_ni)
        alloc_ready_o |-> !$isunknown(alloc_id_o));

endmodule

// File: tb/tb_load_id_tracker.sv
// Directed bench for load_id_tracker; index 0 is the OOO instance,
// index 1 the in-order instance.
module tb_load_id_tracker;

    logic clk = 1'b0;
    logic rst_n;

    logic        av [2];
    logic        rv [2];
    logic        ordy [2];
    logic        kill [2];
    logic [7:0]  am [2];
    logic [2:0]  rid [2];
    logic [63:0] rd [2];

    logic        ar [2];
    logic [2:0]  aid [2];
    logic        ovl [2];
    logic [7:0]  om [2];
    logic [63:0] od [2];
    logic [3:0]  cnt [2];
    logic        err [2];

    int n_chk  = 0;
    int n_fail = 0;
    logic [2:0] tl;
    logic [2:0] ids [4];

    always #5 clk = ~clk;

    load_id_tracker #(.IN_ORDER(1'b0)) dut_ooo (
        .clk_i(clk), .rst_ni(rst_n),
        .alloc_valid_i(av[0]), .alloc_ready_o(ar[0]),
        .alloc_meta_i(am[0]), .alloc_id_o(aid[0]),
        .rsp_valid_i(rv[0]), .rsp_id_i(rid[0]), .rsp_data_i(rd[0]),
        .out_valid_o(ovl[0]), .out_ready_i(ordy[0]),
        .out_meta_o(om[0]), .out_data_o(od[0]),
        .kill_i(kill[0]), .count_o(cnt[0]), .err_o(err[0])
    );

    load_id_tracker #(.IN_ORDER(1'b1)) dut_io (
        .clk_i(clk), .rst_ni(rst_n),
        .alloc_valid_i(av[1]), .alloc_ready_o(ar[1]),
        .alloc_meta_i(am[1]), .alloc_id_o(aid[1]),
        .rsp_valid_i(rv[1]), .rsp_id_i(rid[1]), .rsp_data_i(rd[1]),
        .out_valid_o(ovl[1]), .out_ready_i(ordy[1]),
        .out_meta_o(om[1]), .out_data_o(od[1]),
        .kill_i(kill[1]), .count_o(cnt[1]), .err_o(err[1])
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic alloc(input int k, input logic [7:0] meta,
                         input logic [2:0] exp_id);
        av[k] = 1'b1;
        am[k] = meta;
        #1;
        chk("alloc_ready", 64'(ar[k]), 64'd1);
        chk("alloc_id", 64'(aid[k]), 64'(exp_id));
        tick();
        av[k] = 1'b0;
    endtask

    task automatic rsp(input int k, input logic [2:0] id,
                       input logic [63:0] d);
        rv[k]  = 1'b1;
        rid[k] = id;
        rd[k]  = d;
        tick();
        rv[k] = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            av[k] = 0; rv[k] = 0; ordy[k] = 0; kill[k] = 0;
            am[k] = '0; rid[k] = '0; rd[k] = '0;
        end
        rst_n = 1'b0;
        #2;
        chk("rst_ready", 64'(ar[0]), 64'd1);
        chk("rst_id", 64'(aid[0]), 64'd0);
        chk("rst_valid", 64'(ovl[0]), 64'd0);
        chk("rst_meta", 64'(om[0]), 64'd0);
        chk("rst_data", od[0], 64'd0);
        chk("rst_count", 64'(cnt[0]), 64'd0);
        chk("rst_err", 64'(err[0]), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // OOO fill and out-of-order completion
        for (int i = 0; i < 8; i++) alloc(0, 8'h10 + 8'(i), 3'(i));
        chk("full_ready", 64'(ar[0]), 64'd0);
        chk("full_count", 64'(cnt[0]), 64'd8);
        rsp(0, 3'd5, 64'hA5);
        chk("r5_valid", 64'(ovl[0]), 64'd1);
        chk("r5_data", od[0], 64'hA5);
        chk("r5_meta", 64'(om[0]), 64'h15);
        ordy[0] = 1'b1;
        tick();
        ordy[0] = 1'b0;
        chk("r5_cnt", 64'(cnt[0]), 64'd7);
        chk("r5_valid_off", 64'(ovl[0]), 64'd0);
        alloc(0, 8'h55, 3'd5);
        chk("refill_ready", 64'(ar[0]), 64'd0);

        // Same-cycle release of 0 and response to 3
        rsp(0, 3'd0, 64'h100);
        chk("r0_data", od[0], 64'h100);
        ordy[0] = 1'b1;
        rsp(0, 3'd3, 64'h333);
        chk("same_valid", 64'(ovl[0]), 64'd1);
        chk("same_data", od[0], 64'h333);
        chk("same_meta", 64'(om[0]), 64'h13);
        chk("same_cnt", 64'(cnt[0]), 64'd7);
        tick();
        ordy[0] = 1'b0;
        chk("rel3_cnt", 64'(cnt[0]), 64'd6);
        chk("rel3_id", 64'(aid[0]), 64'd0);

        // Response to a FREE entry
        rsp(0, 3'd0, 64'hBAD);
        chk("err_pulse", 64'(err[0]), 64'd1);
        chk("err_cnt", 64'(cnt[0]), 64'd6);
        chk("err_valid", 64'(ovl[0]), 64'd0);
        tick();
        chk("err_clear", 64'(err[0]), 64'd0);

        // Backpressure: presented entry 7 must stay put over lower-index 1
        rsp(0, 3'd7, 64'h77);
        chk("bp_first", od[0], 64'h77);
        rsp(0, 3'd1, 64'h11);
        for (int i = 0; i < 5; i++) begin
            chk("bp_data", od[0], 64'h77);
            chk("bp_meta", 64'(om[0]), 64'h17);
            tick();
        end
        ordy[0] = 1'b1;
        #1;
        chk("bp_hs_valid", 64'(ovl[0]), 64'd1);
        tick();
        chk("bp_next_data", od[0], 64'h11);
        chk("bp_next_meta", 64'(om[0]), 64'h11);
        tick();
        ordy[0] = 1'b0;
        chk("bp_cnt", 64'(cnt[0]), 64'd4);

        // Kill: pending 2,4,5 and DATA 6
        rsp(0, 3'd6, 64'h66);
        chk("pre_kill_data", od[0], 64'h66);
        kill[0] = 1'b1;
        #1;
        chk("kill_valid", 64'(ovl[0]), 64'd0);
        chk("kill_ready", 64'(ar[0]), 64'd0);
        tick();
        kill[0] = 1'b0;
        #1;
        chk("kill_cnt", 64'(cnt[0]), 64'd3);
        chk("kill_ready_after", 64'(ar[0]), 64'd1);
        rsp(0, 3'd2, 64'h2);
        chk("killed_rsp_valid", 64'(ovl[0]), 64'd0);
        rsp(0, 3'd4, 64'h4);
        rsp(0, 3'd5, 64'h5);
        chk("killed_rsp_valid2", 64'(ovl[0]), 64'd0);
        chk("killed_rsp_err", 64'(err[0]), 64'd0);
        chk("killed_cnt0", 64'(cnt[0]), 64'd0);

        // Kill together with the response of a pending entry
        alloc(0, 8'hAA, 3'd0);
        chk("kr_cnt1", 64'(cnt[0]), 64'd1);
        kill[0] = 1'b1;
        rsp(0, 3'd0, 64'hCC);
        kill[0] = 1'b0;
        chk("kr_cnt0", 64'(cnt[0]), 64'd0);
        chk("kr_err", 64'(err[0]), 64'd0);
        tick();
        chk("kr_valid", 64'(ovl[0]), 64'd0);

        // In-order release
        for (int i = 0; i < 3; i++) alloc(1, 8'h20 + 8'(i), 3'(i));
        rsp(1, 3'd2, 64'h202);
        chk("io_hold2", 64'(ovl[1]), 64'd0);
        rsp(1, 3'd1, 64'h201);
        chk("io_hold1", 64'(ovl[1]), 64'd0);
        rsp(1, 3'd0, 64'h200);
        ordy[1] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("io_valid", 64'(ovl[1]), 64'd1);
            chk("io_meta", 64'(om[1]), 64'h20 + 64'(i));
            chk("io_data", od[1], 64'h200 + 64'(i));
            tick();
        end
        ordy[1] = 1'b0;
        chk("io_empty", 64'(ovl[1]), 64'd0);
        chk("io_cnt", 64'(cnt[1]), 64'd0);

        // In-order wrap: batches of 4, responses reversed with random gaps
        tl = 3'd3;
        for (int b = 0; b < 5; b++) begin
            for (int j = 0; j < 4; j++) begin
                ids[j] = tl;
                alloc(1, 8'(b * 4 + j), tl);
                tl = tl + 3'd1;
            end
            for (int j = 3; j >= 0; j--) begin
                repeat ($urandom_range(0, 2)) tick();
                rsp(1, ids[j], 64'(b * 4 + j) << 8);
            end
            ordy[1] = 1'b1;
            for (int j = 0; j < 4; j++) begin
                #1;
                chk("wrap_valid", 64'(ovl[1]), 64'd1);
                chk("wrap_meta", 64'(om[1]), 64'(b * 4 + j));
                chk("wrap_data", od[1], 64'(b * 4 + j) << 8);
                tick();
            end
            ordy[1] = 1'b0;
        end

        // In-order kill: head skips KILLED and FREE entries
        alloc(1, 8'h70, 3'd7);
        alloc(1, 8'h71, 3'd0);
        rsp(1, 3'd0, 64'h71);
        chk("iok_hold", 64'(ovl[1]), 64'd0);
        kill[1] = 1'b1;
        tick();
        kill[1] = 1'b0;
        #1;
        chk("iok_cnt", 64'(cnt[1]), 64'd1);
        chk("iok_ready", 64'(ar[1]), 64'd1);
        chk("iok_id", 64'(aid[1]), 64'd1);
        tick();
        tick();
        rsp(1, 3'd7, 64'h7);
        chk("iok_cnt0", 64'(cnt[1]), 64'd0);
        chk("iok_err", 64'(err[1]), 64'd0);
        chk("iok_valid", 64'(ovl[1]), 64'd0);

        // Asynchronous reset mid-stream
        alloc(0, 8'h3C, 3'd0);
        rsp(0, 3'd0, 64'hDEAD);
        chk("pre_rst_valid", 64'(ovl[0]), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(ovl[0]), 64'd0);
        chk("arst_meta", 64'(om[0]), 64'd0);
        chk("arst_data", od[0], 64'd0);
        chk("arst_cnt", 64'(cnt[0]), 64'd0);
        chk("arst_ready", 64'(ar[0]), 64'd1);
        chk("arst_id", 64'(aid[0]), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        rsp(0, 3'd0, 64'hBEEF);
        chk("late_rsp_err", 64'(err[0]), 64'd1);
        chk("late_rsp_valid", 64'(ovl[0]), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
